// File: rtl/dec_stream_ctrl.sv
// rtl/dec_stream_ctrl.sv - word-stream sequencer around a combinational 128-bit decrypt core.
// Optional key reuse across blocks when DEC_KEY_RETAIN_EN is defined (adds input key_keep).
module dec_stream_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic [0:127]  dec_en_key,
    output logic [0:127]  dec_key,
    input  logic [0:127]  dec_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
`ifdef DEC_KEY_RETAIN_EN
    input  logic          key_keep,
`endif
    output logic          busy
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LD_KEY,
        LD_CT,
        SETTLE,
        DRAIN
    } state_t;

    state_t       state;
    logic [1:0]   in_cnt;
    logic [1:0]   out_cnt;
    logic [7:0]   settle_cnt;
    logic [0:127] result;

    logic         keep_key;
    logic         loading;
    logic         draining;
    logic         in_fire;
    logic         out_fire;
    logic [6:0]   in_base;
    logic [6:0]   out_base;

`ifdef DEC_KEY_RETAIN_EN
    assign keep_key = key_keep;
`else
    assign keep_key = 1'b0;
`endif

    assign loading  = (state == LD_KEY) || (state == LD_CT);
    assign draining = (state == DRAIN);
    assign in_fire  = in_valid && loading;
    assign out_fire = out_ready && draining;
    assign in_base  = {in_cnt, 5'b0};
    assign out_base = {out_cnt, 5'b0};

    // Handshake outputs are quieted by rst directly so nothing leaks out
    // between rst rising and the clearing edge.
    assign in_ready  = loading && !rst;
    assign out_valid = draining && !rst;
    assign out_data  = out_valid ? result[out_base +: 32] : 32'h0;
    assign busy      = !rst && !((state == LD_KEY) && (in_cnt == 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_KEY;
            in_cnt     <= 2'd0;
            out_cnt    <= 2'd0;
            settle_cnt <= 8'd0;
            dec_key    <= '0;
            dec_en_key <= '0;
            result     <= '0;
        end else begin
            case (state)
                LD_KEY: begin
                    if (in_fire) begin
                        dec_key[in_base +: 32] <= in_data;
                        in_cnt <= in_cnt + 2'd1;
                        if (in_cnt == 2'd3) begin
                            state <= LD_CT;
                        end
                    end
                end
                LD_CT: begin
                    if (in_fire) begin
                        dec_en_key[in_base +: 32] <= in_data;
                        in_cnt <= in_cnt + 2'd1;
                        if (in_cnt == 2'd3) begin
                            state      <= SETTLE;
                            settle_cnt <= 8'd0;
                        end
                    end
                end
                SETTLE: begin
                    // Key and ciphertext registers are untouched here, so the
                    // core inputs stay frozen until the capture edge.
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        result  <= dec_data;
                        out_cnt <= 2'd0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + 2'd1;
                        if (out_cnt == 2'd3) begin
                            state <= keep_key ? LD_CT : LD_KEY;
                        end
                    end
                end
                default: begin
                    state <= LD_KEY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_stream_ctrl.sv
// tb/tb_dec_stream_ctrl.sv - self-checking bench with a behavioural AES-128 inverse cipher as the core.
module tb_dec_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst_aux;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         out_ready;
    logic         key_keep;

    logic         in_ready_m, out_valid_m, busy_m;
    logic [31:0]  out_data_m;
    logic [0:127] dec_en_key_m, dec_key_m, dec_data_m;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [31:0]  out_data_a;
    logic [0:127] dec_en_key_a, dec_key_a, dec_data_a;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [31:0]  out_data_b;
    logic [0:127] dec_en_key_b, dec_key_b, dec_data_b;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural AES-128 inverse cipher ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] y);
        return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) t[i] = isb(s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]);
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    assign dec_data_m = aes_dec(dec_key_m, dec_en_key_m);
    assign dec_data_a = aes_dec(dec_key_a, dec_en_key_a);
    assign dec_data_b = aes_dec(dec_key_b, dec_en_key_b);

    dec_stream_ctrl #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
        .dec_en_key(dec_en_key_m), .dec_key(dec_key_m), .dec_data(dec_data_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
`ifdef DEC_KEY_RETAIN_EN
        .key_keep(key_keep),
`endif
        .busy(busy_m)
    );

    dec_stream_ctrl #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst(rst_aux), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .dec_en_key(dec_en_key_a), .dec_key(dec_key_a), .dec_data(dec_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
`ifdef DEC_KEY_RETAIN_EN
        .key_keep(key_keep),
`endif
        .busy(busy_a)
    );

    dec_stream_ctrl #(.SETTLE_CYCLES(5)) u_dut_s5 (
        .clk(clk), .rst(rst_aux), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .dec_en_key(dec_en_key_b), .dec_key(dec_key_b), .dec_data(dec_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
`ifdef DEC_KEY_RETAIN_EN
        .key_keep(key_keep),
`endif
        .busy(busy_b)
    );

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_word(input logic [31:0] w, output int t_acc);
        int  n = 0;
        bit  done = 0;
        t_acc = -1;
        repeat ($urandom_range(1, 0)) step();
        in_valid = 1'b1;
        in_data  = w;
        while (!done && n < 40) begin
            if (in_ready_m) begin
                done  = 1;
                t_acc = cyc;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_word: word %h not accepted, in_ready=%b required 1", w, in_ready_m);
        end
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] c, output int t_last);
        for (int j = 0; j < 4; j++) send_word(k[127-32*j -: 32], t_last);
        for (int j = 0; j < 4; j++) send_word(c[127-32*j -: 32], t_last);
    endtask

    task automatic recv_block(input logic [127:0] e, input logic [127:0] k, input logic [127:0] c,
                              input string tag, input int max_stall, input bit expect_idle);
        for (int j = 0; j < 4; j++) begin
            int n = 0;
            out_ready = 1'b0;
            while (!out_valid_m && n < 40) begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = $urandom;
                n_chk++;
                if (in_ready_m !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s settle_in_ready: got %b required 0", tag, in_ready_m);
                end
                step();
                n++;
            end
            n_chk++;
            if (!out_valid_m) begin
                n_fail++;
                $display("FAIL %s out_valid_timeout: word %0d got out_valid=0 required 1", tag, j);
                in_valid = 1'b0;
                return;
            end
            repeat ($urandom_range(max_stall, 0)) begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = $urandom;
                n_chk++;
                if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s stall_flags: out_valid=%b in_ready=%b required 1/0", tag, out_valid_m, in_ready_m);
                end
                step();
            end
            n_chk++;
            if (out_data_m !== e[127-32*j -: 32]) begin
                n_fail++;
                $display("FAIL %s out_word%0d: got %h required %h", tag, j, out_data_m, e[127-32*j -: 32]);
            end
            n_chk++;
            if (dec_key_m !== k || dec_en_key_m !== c) begin
                n_fail++;
                $display("FAIL %s core_inputs_held: key %h ct %h required %h %h", tag, dec_key_m, dec_en_key_m, k, c);
            end
            in_valid  = (j == 3) ? 1'b1 : 1'($urandom_range(1, 0));
            in_data   = $urandom;
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_chk++;
        if (busy_m !== !expect_idle || in_ready_m !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_drain: busy=%b in_ready=%b required %b/1", tag, busy_m, in_ready_m, !expect_idle);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if ({in_ready_m, out_valid_m, busy_m} !== 3'b000 || out_data_m !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/vld/busy=%b data=%h required 000 / 0",
                     {in_ready_m, out_valid_m, busy_m}, out_data_m);
        end
        n_chk++;
        if (dec_key_m !== 128'h0 || dec_en_key_m !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_core_regs: key=%h ct=%h required 0", dec_key_m, dec_en_key_m);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready_m !== 1'b1 || busy_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", in_ready_m, busy_m);
        end
        step();
    endtask

    task automatic test_fips();
        int t, first;
        send_word(FIPS_KEY[127:96], t);
        n_chk++;
        if (busy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL fips_busy: got %b required 1", busy_m);
        end
        for (int j = 1; j < 4; j++) send_word(FIPS_KEY[127-32*j -: 32], t);
        for (int j = 0; j < 4; j++) send_word(FIPS_CT[127-32*j -: 32], t);
        first = -1;
        while (first < 0 && cyc < t + 20) begin
            if (out_valid_m) first = cyc;
            else step();
        end
        n_chk++;
        if (first != t + 3) begin
            n_fail++;
            $display("FAIL fips_latency: first out_valid at %0d required %0d", first, t + 3);
        end
        recv_block(FIPS_PT, FIPS_KEY, FIPS_CT, "fips", 2, 1'b1);
    endtask

    task automatic test_stall();
        int t, n;
        send_block(FIPS_KEY, FIPS_CT, t);
        n = 0;
        while (!out_valid_m && n < 20) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (out_valid_m !== 1'b1 || out_data_m !== 32'h00112233) begin
                n_fail++;
                $display("FAIL stall_hold%0d: out_valid=%b data=%h required 1 / 00112233", i, out_valid_m, out_data_m);
            end
            step();
        end
        recv_block(FIPS_PT, FIPS_KEY, FIPS_CT, "stall", 0, 1'b1);
    endtask

    task automatic test_random_blocks();
        logic [127:0] k, c;
        int t;
        for (int b = 0; b < 5; b++) begin
            k = rand128();
            c = rand128();
            send_block(k, c, t);
            recv_block(aes_dec(k, c), k, c, "random", 3, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        int t;
        logic [127:0] junk;
        junk = rand128();
        for (int j = 0; j < 4; j++) send_word(junk[127-32*j -: 32], t);
        for (int j = 0; j < 2; j++) send_word($urandom, t);
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready_m !== 1'b0 || busy_m !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_assert: in_ready=%b busy=%b required 0/0", in_ready_m, busy_m);
        end
        step();
        step();
        n_chk++;
        if ({in_ready_m, out_valid_m, busy_m} !== 3'b000 || out_data_m !== 32'h0 ||
            dec_key_m !== 128'h0 || dec_en_key_m !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: rdy/vld/busy=%b data=%h key=%h ct=%h required all zero",
                     {in_ready_m, out_valid_m, busy_m}, out_data_m, dec_key_m, dec_en_key_m);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_abandon: out_valid=%b in_ready=%b required 0/1", out_valid_m, in_ready_m);
            end
            step();
        end
        send_block(FIPS_KEY, FIPS_CT, t);
        recv_block(FIPS_PT, FIPS_KEY, FIPS_CT, "midrst", 1, 1'b1);
    endtask

    task automatic test_latency();
        logic [127:0] k, c, e;
        int t, fm, fa, fb, im, ia, ib;
        k = rand128();
        c = rand128();
        e = aes_dec(k, c);
        rst_aux = 1'b0;
        step();
        send_block(k, c, t);
        fm = -1; fa = -1; fb = -1;
        out_ready = 1'b0;
        while (cyc <= t + 10) begin
            if (out_valid_m && fm < 0) fm = cyc;
            if (out_valid_a && fa < 0) fa = cyc;
            if (out_valid_b && fb < 0) fb = cyc;
            step();
        end
        n_chk++;
        if (fa != t + 2 || fm != t + 3 || fb != t + 6) begin
            n_fail++;
            $display("FAIL latency: S1/S2/S5 first valid at %0d/%0d/%0d required %0d/%0d/%0d",
                     fa, fm, fb, t + 2, t + 3, t + 6);
        end
        im = 0; ia = 0; ib = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_m && im < 4) begin
                n_chk++;
                if (out_data_m !== e[127-32*im -: 32]) begin
                    n_fail++;
                    $display("FAIL latency_s2_word%0d: got %h required %h", im, out_data_m, e[127-32*im -: 32]);
                end
                im++;
            end
            if (out_valid_a && ia < 4) begin
                n_chk++;
                if (out_data_a !== e[127-32*ia -: 32]) begin
                    n_fail++;
                    $display("FAIL latency_s1_word%0d: got %h required %h", ia, out_data_a, e[127-32*ia -: 32]);
                end
                ia++;
            end
            if (out_valid_b && ib < 4) begin
                n_chk++;
                if (out_data_b !== e[127-32*ib -: 32]) begin
                    n_fail++;
                    $display("FAIL latency_s5_word%0d: got %h required %h", ib, out_data_b, e[127-32*ib -: 32]);
                end
                ib++;
            end
            step();
        end
        out_ready = 1'b0;
        n_chk++;
        if (im != 4 || ia != 4 || ib != 4 || busy_m !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_drain: words %0d/%0d/%0d busy %b%b%b required 4/4/4 busy 000",
                     ia, im, ib, busy_a, busy_m, busy_b);
        end
        rst_aux = 1'b1;
        step();
    endtask

`ifdef DEC_KEY_RETAIN_EN
    task automatic test_key_keep();
        logic [127:0] c2;
        int t;
        key_keep = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        send_block(FIPS_KEY, FIPS_CT, t);
        recv_block(FIPS_PT, FIPS_KEY, FIPS_CT, "keep_first", 1, 1'b0);
        c2 = rand128();
        for (int j = 0; j < 4; j++) send_word(c2[127-32*j -: 32], t);
        n_chk++;
        if (in_ready_m !== 1'b0 || busy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL keep_four_words: in_ready=%b busy=%b required 0/1", in_ready_m, busy_m);
        end
        key_keep = 1'b0;
        recv_block(aes_dec(FIPS_KEY, c2), FIPS_KEY, c2, "keep_second", 1, 1'b1);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        rst_aux   = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        key_keep  = 1'b0;
        n_chk++;
        if (aes_dec(FIPS_KEY, FIPS_CT) !== FIPS_PT) begin
            n_fail++;
            $display("FAIL core_model: got %h required %h", aes_dec(FIPS_KEY, FIPS_CT), FIPS_PT);
        end
        test_reset();
        test_fips();
        test_stall();
        test_random_blocks();
        test_mid_reset();
        test_latency();
`ifdef DEC_KEY_RETAIN_EN
        test_key_keep();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_stream_ctrl.md
DEC_STREAM_CTRL -- requirements
Module: dec_stream_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of clock cycles allowed for the combinational decrypt core to settle; legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: the key or ciphertext word.
REQ-007 The block SHALL have port dec_en_key, output, 128 bits [0:127]: the ciphertext driven to the decrypt core.
REQ-008 The block SHALL have port dec_key, output, 128 bits [0:127]: the cipher key driven to the decrypt core.
REQ-009 The block SHALL have port dec_data, input, 128 bits [0:127]: the plaintext returned by the decrypt core.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the plaintext word is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 The block SHALL have port out_data, output, 32 bits: the plaintext word.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than LD_KEY with zero words loaded.

Function
REQ-014 FSM SHALL have states LD_KEY, LD_CT, SETTLE, DRAIN.
REQ-015 Input handshake SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in LD_KEY and LD_CT.
REQ-016 In LD_KEY, accepted word k (0..3) SHALL load dec_key bits [32k:32k+31]; the 4th word SHALL move the FSM to LD_CT.
REQ-017 In LD_CT, accepted word k (0..3) SHALL load dec_en_key bits [32k:32k+31]; the 4th word SHALL move the FSM to SETTLE and clear the settle counter.
REQ-018 In SETTLE, the 8-bit counter SHALL increment each cycle; in the cycle the counter equals SETTLE_CYCLES-1, dec_data SHALL be captured into the 128-bit result register and the FSM SHALL move to DRAIN.
REQ-019 Latency: if the last ciphertext word is accepted in cycle T, out_valid SHALL first be high in cycle T+SETTLE_CYCLES+1.
REQ-020 dec_key and dec_en_key SHALL be held stable from the last ciphertext word through the capture cycle.
REQ-021 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal result bits [32j:32j+31] for word index j; j SHALL advance only on out_valid && out_ready.
REQ-022 out_data SHALL hold its value while out_valid=1 and out_ready=0 (no drop, no duplicate).
REQ-023 The 4th output handshake SHALL return the FSM to LD_KEY with word counters at 0; no input SHALL be accepted in that same cycle.
REQ-024 in_valid SHALL be ignored outside the LD states; out_ready SHALL be ignored outside DRAIN.

Reset
REQ-025 While rst=1, FSM SHALL enter LD_KEY; word counters, settle counter, dec_key, dec_en_key and the result register SHALL become 0; outputs SHALL be in_ready=0, out_valid=0, out_data=0, busy=0.
REQ-026 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-027 rst asserted in any state SHALL abandon the block in progress without emitting any further output word.

Configuration
REQ-028 With macro DEC_KEY_RETAIN_EN defined, the block SHALL have an extra input key_keep (1 bit).
REQ-029 With DEC_KEY_RETAIN_EN defined, when key_keep=1 in the cycle the FSM enters LD_KEY from DRAIN, the block SHALL go directly to LD_CT and reuse the held dec_key.
REQ-030 With DEC_KEY_RETAIN_EN defined, key_keep SHALL be ignored after reset; the first block always loads a key.
REQ-031 Without DEC_KEY_RETAIN_EN, the key_keep port SHALL not exist and every block SHALL load 8 words.

Verification
REQ-032 Bench SHALL drive key 000102030405060708090a0b0c0d0e0f and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a to a real decrypt core -> out words 00112233, 44556677, 8899aabb, ccddeeff.
REQ-033 Bench SHALL hold out_ready=0 for 5 cycles in DRAIN -> out_valid stays 1 and out_data stays 00112233; no word is lost.
REQ-034 Bench SHALL set SETTLE_CYCLES=1 and SETTLE_CYCLES=5 -> first out_valid at T+2 and T+6 respectively.
REQ-035 Bench SHALL assert rst after 6 input words -> in_ready=0 during reset, all-zero outputs, then a fresh 8-word block decrypts correctly.
REQ-036 Bench SHALL run with DEC_KEY_RETAIN_EN and key_keep=1 on a second block -> only 4 words are accepted and the same key decrypts the second ciphertext correctly.
REQ-037 Bench SHALL toggle in_valid randomly during SETTLE and DRAIN -> in_ready=0 and no register changes.
